booth_r8_seq_decoder: RTL and testbench

Sequential radix-8 Booth digit decoder/accumulator. It is the consumer side of the booth_encoder bank: it takes one encoded digit per handshake (single/double/triple/quad/neg, least-significant group first) and a latched multiplicand. It selects ±{0,1,2,3,4}×multiplicand, shifts by 3·group, and accumulates into a 2·WIDTH unsigned product. It sits between the multiplier-side pre-processing bank and the result writeback of the serial multiplier datapath.

---
 rtl/booth_r8_pkg.sv | 27 ++
 rtl/booth_r8_pp_sel.sv | 29 ++
 rtl/booth_r8_seq_decoder.sv | 122 ++++++++++++
 tb/tb_booth_r8_seq_decoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_r8_pkg.sv
// Shared types and constants for the radix-8 Booth sequential digit decoder.
package booth_r8_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    ACCUM   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One encoded Booth digit: magnitude one-hot {s,d,t,q} plus sign n.
  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } digit_t;

  localparam int SHIFT_PER_GROUP = 3;

  // Number of 3-bit Booth groups needed to cover an unsigned operand of this width.
  function automatic int groups_of(input int width);
    return (width + 3) / 3;
  endfunction

endpackage

// File: rtl/booth_r8_pp_sel.sv
// Partial-product select: maps one Booth digit to +/-{0,1,2,3,4} x multiplicand (two's complement).
module booth_r8_pp_sel
  import booth_r8_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int ACC_W = 2 * WIDTH
) (
  input  digit_t             dig,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH+1:0]   m3,
  output logic [ACC_W-1:0]   pp
);

  logic [WIDTH+1:0] mag;
  logic [ACC_W-1:0] mag_ext;

  // Priority s > d > t > q keeps the decode defined for multi-hot digits.
  always_comb begin
    mag = '0;
    if (dig.s)      mag = {2'b00, mc};
    else if (dig.d) mag = {1'b0, mc, 1'b0};
    else if (dig.t) mag = m3;
    else if (dig.q) mag = {mc, 2'b00};
  end

  assign mag_ext = ACC_W'(mag);
  assign pp      = dig.n ? (~mag_ext + 1'b1) : mag_ext;

endmodule

// File: rtl/booth_r8_seq_decoder.sv
// Sequential radix-8 Booth digit decoder/accumulator, one digit per handshake, LSB group first.
// Optional multi-hot digit detection is enabled with `define BOOTH_DEC_ONEHOT_CHECK_EN.
module booth_r8_seq_decoder
  import booth_r8_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int GROUPS = groups_of(WIDTH),
  localparam int ACC_W  = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mc,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic             dig_s,
  input  logic             dig_d,
  input  logic             dig_t,
  input  logic             dig_q,
  input  logic             dig_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] product,
  output logic             err
);

  localparam int CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  // Handshakes: a transfer happens on a rising clk edge when valid and ready are both high;
  // ready signals depend only on state, and valid is never required to wait for ready.

  state_t           state, next_state;
  logic [WIDTH-1:0] mc_q;
  logic [WIDTH+1:0] m3_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  digit_t           dig;
  logic [ACC_W-1:0] pp_raw, pp_eff, pp_shift;
  logic             start, dig_fire;

  assign dig      = '{s: dig_s, d: dig_d, t: dig_t, q: dig_q, n: dig_n};
  assign start    = (state == IDLE) && in_valid;
  assign dig_fire = (state == ACCUM) && dig_valid;

  booth_r8_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .dig (dig),
    .mc  (mc_q),
    .m3  (m3_q),
    .pp  (pp_raw)
  );

`ifdef BOOTH_DEC_ONEHOT_CHECK_EN
  logic multi_hot, err_q;

  assign multi_hot = ($countones({dig_s, dig_d, dig_t, dig_q}) > 1);
  assign pp_eff    = multi_hot ? '0 : pp_raw;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_q <= 1'b0;
    else if (start)                 err_q <= 1'b0;
    else if (dig_fire && multi_hot) err_q <= 1'b1;
  end
`else
  assign pp_eff = pp_raw;
  assign err    = 1'b0;
`endif

  assign pp_shift = pp_eff << (SHIFT_PER_GROUP * cnt);
  assign product  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    dig_ready  = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = PRECOMP;
      end
      PRECOMP: next_state = ACCUM;
      ACCUM: begin
        dig_ready = 1'b1;
        if (dig_valid && (cnt == CNT_W'(GROUPS - 1))) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Intermediate sums may wrap negative; the final product is exact modulo 2^ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q <= '0;
      m3_q <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      if (start) begin
        mc_q <= mc;
        acc  <= '0;
        cnt  <= '0;
      end
      if (state == PRECOMP) m3_q <= {2'b00, mc_q} + {1'b0, mc_q, 1'b0};
      if (dig_fire) begin
        acc <= acc + pp_shift;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_r8_seq_decoder.sv
// Self-checking bench for booth_r8_seq_decoder against an arithmetic Booth reference model.
module tb_booth_r8_seq_decoder;

  localparam int WIDTH  = 8;
  localparam int GROUPS = 3;
  localparam int ACC_W  = 16;

  typedef logic [4:0] dig_arr_t [GROUPS];  // each digit packed as {s,d,t,q,n}

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] mc = '0;
  logic             dig_valid = 1'b0;
  logic             dig_ready;
  logic             dig_s = 1'b0, dig_d = 1'b0, dig_t = 1'b0, dig_q = 1'b0, dig_n = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] product;
  logic             err;

  logic [ACC_W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  booth_r8_seq_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mc        (mc),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_s     (dig_s),
    .dig_d     (dig_d),
    .dig_t     (dig_t),
    .dig_q     (dig_q),
    .dig_n     (dig_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .err       (err)
  );

  // ---------------- reference model ----------------
  function automatic bit is_multi_hot(input logic [4:0] d);
    return ($countones(d[4:1]) > 1);
  endfunction

  function automatic int dig_value(input logic [4:0] d);
    int mag;
    if (d[4])      mag = 1;
    else if (d[3]) mag = 2;
    else if (d[2]) mag = 3;
    else if (d[1]) mag = 4;
    else           mag = 0;
`ifdef BOOTH_DEC_ONEHOT_CHECK_EN
    if (is_multi_hot(d)) mag = 0;
`endif
    return d[0] ? -mag : mag;
  endfunction

  function automatic logic [ACC_W-1:0] model_product(input logic [WIDTH-1:0] m, input dig_arr_t d);
    longint sum;
    sum = 0;
    for (int g = 0; g < GROUPS; g++)
      sum += longint'(m) * longint'(dig_value(d[g])) * (longint'(1) << (3 * g));
    return sum[ACC_W-1:0];
  endfunction

  function automatic logic model_err(input dig_arr_t d);
    logic e;
    e = 1'b0;
`ifdef BOOTH_DEC_ONEHOT_CHECK_EN
    for (int g = 0; g < GROUPS; g++) if (is_multi_hot(d[g])) e = 1'b1;
`endif
    return e;
  endfunction

  // Radix-8 Booth recoding: digit = -4*y[3g+2] + 2*y[3g+1] + y[3g] + y[3g-1], sign = y[3g+2].
  function automatic dig_arr_t booth_encode(input logic [WIDTH-1:0] y);
    dig_arr_t r;
    logic [WIDTH+2:0] ye;
    int v, mag;
    ye = {2'b00, y, 1'b0};
    for (int g = 0; g < GROUPS; g++) begin
      v = 2 * int'(ye[3*g+2]) + int'(ye[3*g+1]) + int'(ye[3*g]) - 4 * int'(ye[3*g+3]);
      mag = (v < 0) ? -v : v;
      r[g] = 5'b00000;
      r[g][0] = ye[3*g+3];
      case (mag)
        1: r[g][4] = 1'b1;
        2: r[g][3] = 1'b1;
        3: r[g][2] = 1'b1;
        4: r[g][1] = 1'b1;
        default: ;
      endcase
    end
    return r;
  endfunction

  // ---------------- driver tasks (always return on a negedge) ----------------
  task automatic run_op(input logic [WIDTH-1:0] m, input dig_arr_t d, input int gap_at,
                        input int gap_len, output logic [ACC_W-1:0] prod, output logic err_o,
                        output int lat);
    int w, g, gap_cnt;
    bit fire;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    mc = m;
    @(negedge clk);
    in_valid = 1'b0;
    mc = WIDTH'($urandom);
    lat = 1;
    g = 0;
    gap_cnt = 0;
    while (!out_valid && lat < 200) begin
      if (dig_ready && g == gap_at && gap_cnt < gap_len) begin
        dig_valid = 1'b0;
        gap_cnt++;
      end else if (g < GROUPS) begin
        dig_valid = 1'b1;
        {dig_s, dig_d, dig_t, dig_q, dig_n} = d[g];
      end else begin
        dig_valid = 1'b0;
      end
      fire = dig_ready && dig_valid;
      @(negedge clk);
      lat++;
      if (fire) g++;
    end
    dig_valid = 1'b0;
    {dig_s, dig_d, dig_t, dig_q, dig_n} = 5'b0;
    if (!out_valid) begin
      errors++;
      $display("FAIL op_timeout: out_valid=%0b after %0d cycles, need 1", out_valid, lat);
    end
    prod = product;
    err_o = err;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    if (dig_ready !== 1'b0) begin errors++; $display("FAIL reset_dig_ready: got %b need 0", dig_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    if (product !== '0)     begin errors++; $display("FAIL reset_product: got %h need 0", product); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b need 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [ACC_W-1:0] p;
    logic e;
    int lat;
    run_op(8'd200, booth_encode(8'd255), GROUPS, 0, p, e, lat);
    checks += 3;
    if (p !== 16'hC738) begin errors++; $display("FAIL prod_200x255: got %h need c738", p); end
    if (e !== 1'b0)     begin errors++; $display("FAIL err_200x255: got %b need 0", e); end
    if (lat != 5)       begin errors++; $display("FAIL latency: got %0d need 5", lat); end
    finish_op();
    run_op(8'd255, booth_encode(8'd255), GROUPS, 0, p, e, lat);
    checks++;
    if (p !== 16'hFE01) begin errors++; $display("FAIL prod_255x255: got %h need fe01", p); end
    finish_op();
    run_op(8'd0, booth_encode(WIDTH'($urandom)), GROUPS, 0, p, e, lat);
    checks++;
    if (p !== 16'h0000) begin errors++; $display("FAIL prod_mc0: got %h need 0", p); end
    finish_op();
  endtask

  task automatic test_gap();
    logic [ACC_W-1:0] p;
    logic e;
    int lat;
    run_op(8'd200, booth_encode(8'd255), 1, 3, p, e, lat);
    checks += 2;
    if (p !== 16'hC738) begin errors++; $display("FAIL gap_prod: got %h need c738", p); end
    if (lat != 8)       begin errors++; $display("FAIL gap_latency: got %0d need 8", lat); end
    finish_op();
  endtask

  task automatic test_random_booth();
    logic [ACC_W-1:0] p, m16;
    logic [WIDTH-1:0] m, y;
    logic e;
    int lat, gap_at, gap_len;
    for (int i = 0; i < 24; i++) begin
      m = WIDTH'($urandom);
      y = WIDTH'($urandom);
      if (i == 0) y = 8'd0;
      if (i == 1) m = 8'hFF;
      gap_at  = $urandom_range(0, GROUPS);
      gap_len = $urandom_range(0, 3);
      m16 = ACC_W'(m);
      exp_q.push_back(m16 * ACC_W'(y));
      run_op(m, booth_encode(y), gap_at, gap_len, p, e, lat);
      checks += 3;
      if (p !== exp_q.pop_front()) begin
        errors++;
        $display("FAIL rand_booth_prod: mc=%0d y=%0d got %0d", m, y, p);
      end
      if (e !== 1'b0) begin errors++; $display("FAIL rand_booth_err: got %b need 0", e); end
      if (lat != 2 + GROUPS + ((gap_at < GROUPS) ? gap_len : 0)) begin
        errors++;
        $display("FAIL rand_booth_latency: got %0d need %0d", lat,
                 2 + GROUPS + ((gap_at < GROUPS) ? gap_len : 0));
      end
      finish_op();
    end
  endtask

  task automatic test_random_digits();
    logic [ACC_W-1:0] p, expv;
    logic [WIDTH-1:0] m;
    dig_arr_t d;
    logic e;
    int lat;
    for (int i = 0; i < 24; i++) begin
      m = WIDTH'($urandom);
      for (int g = 0; g < GROUPS; g++) d[g] = 5'($urandom);
      exp_q.push_back(model_product(m, d));
      run_op(m, d, GROUPS, 0, p, e, lat);
      expv = exp_q.pop_front();
      checks += 2;
      if (p !== expv) begin errors++; $display("FAIL rand_dig_prod: got %h need %h", p, expv); end
      if (e !== model_err(d)) begin
        errors++;
        $display("FAIL rand_dig_err: got %b need %b", e, model_err(d));
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] p, hold;
    logic e;
    int lat;
    run_op(8'd123, booth_encode(8'd45), GROUPS, 0, p, e, lat);
    hold = p;
    checks++;
    if (p !== 16'd5535) begin errors++; $display("FAIL bp_prod: got %0d need 5535", p); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      mc = WIDTH'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || product !== hold || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: ov=%b prod=%h ir=%b need ov=1 prod=%h ir=0",
                 out_valid, product, in_ready, hold);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== hold) begin
      errors++;
      $display("FAIL bp_release: ir=%b ov=%b prod=%h need ir=1 ov=0 prod=%h",
               in_ready, out_valid, product, hold);
    end
    run_op(8'd17, booth_encode(8'd3), GROUPS, 0, p, e, lat);
    checks++;
    if (p !== 16'd51) begin errors++; $display("FAIL bp_next_prod: got %0d need 51", p); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [ACC_W-1:0] p;
    logic e;
    int lat;
    in_valid = 1'b1;
    mc = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    dig_valid = 1'b1;
    {dig_s, dig_d, dig_t, dig_q, dig_n} = 5'b00010;
    repeat (2) @(negedge clk);
    dig_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %b need 1", in_ready); end
    if (dig_ready !== 1'b0) begin errors++; $display("FAIL midrst_dig_ready: got %b need 0", dig_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b need 0", out_valid); end
    if (product !== '0)     begin errors++; $display("FAIL midrst_product: got %h need 0", product); end
    if (err !== 1'b0)       begin errors++; $display("FAIL midrst_err: got %b need 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd7, booth_encode(8'd9), GROUPS, 0, p, e, lat);
    checks++;
    if (p !== 16'd63) begin errors++; $display("FAIL midrst_prod: got %0d need 63", p); end
    finish_op();
  endtask

  task automatic test_onehot();
    logic [ACC_W-1:0] p, expv;
    logic e, expe;
    int lat;
    dig_arr_t d;
    d = '{5'b11000, 5'b00010, 5'b00000};
`ifdef BOOTH_DEC_ONEHOT_CHECK_EN
    expv = 16'd1600;
    expe = 1'b1;
`else
    expv = 16'd1650;
    expe = 1'b0;
`endif
    run_op(8'd50, d, GROUPS, 0, p, e, lat);
    checks += 2;
    if (p !== expv) begin errors++; $display("FAIL onehot_prod: got %0d need %0d", p, expv); end
    if (e !== expe) begin errors++; $display("FAIL onehot_err: got %b need %b", e, expe); end
    finish_op();
    run_op(8'd10, booth_encode(8'd10), GROUPS, 0, p, e, lat);
    checks += 2;
    if (e !== 1'b0)    begin errors++; $display("FAIL onehot_err_clear: got %b need 0", e); end
    if (p !== 16'd100) begin errors++; $display("FAIL onehot_next_prod: got %0d need 100", p); end
    finish_op();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_gap();
    test_random_booth();
    test_random_digits();
    test_back_to_back();
    test_reset_mid();
    test_onehot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
